// File: rtl/dup_reg_checker_pkg.sv
// Shared types and defaults for the redundant-register checkers.
package fifoss_chk_pkg;

  typedef enum logic [1:0] {
    ALERT_IDLE,
    ALERT_REQ,
    ALERT_WAIT_LOW
  } alert_state_e;

  localparam int unsigned DEFAULT_FATAL_THRESH = 3;

endpackage

// File: rtl/dup_reg_checker_alert_sender.sv
// 4-phase req/ack alert sender with a single-bit pending latch for
// events that arrive while a handshake is already in flight.
module alert_sender
  import fifoss_chk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic event_i,
  input  logic ack_i,
  output logic req_o
);

  alert_state_e state_q, state_d;
  logic         pending_q, pending_d;
  logic         req_q, req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ALERT_IDLE;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      ALERT_IDLE: begin
        // Leaving IDLE consumes pending, even if a new event coincides.
        if (event_i || pending_q) begin
          state_d   = ALERT_REQ;
          pending_d = 1'b0;
        end
      end
      ALERT_REQ: begin
        if (event_i) pending_d = 1'b1;
        if (ack_i)   state_d   = ALERT_WAIT_LOW;
      end
      ALERT_WAIT_LOW: begin
        if (event_i) pending_d = 1'b1;
        if (!ack_i)  state_d   = ALERT_IDLE;
      end
      default: begin
        state_d   = ALERT_IDLE;
        pending_d = 1'b0;
      end
    endcase
    req_d = (state_d == ALERT_REQ);
  end

  assign req_o = req_q;

endmodule

// File: rtl/dup_reg_checker.sv
// Compares two redundant copies of a register each enabled cycle; records
// first syndrome, saturating mismatch count and sticky fatal; raises alerts.
module dup_reg_checker
  import fifoss_chk_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned FATAL_THRESH = DEFAULT_FATAL_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             chk_en_i,
  input  logic             clr_i,
  input  logic             alert_ack_i,
  output logic             alert_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] err_syn_o,
  output logic             err_valid_o,
  output logic             fatal_o
);

  localparam logic [CNT_W-1:0] THRESH = FATAL_THRESH[CNT_W-1:0];

  logic             mism;
  logic [WIDTH-1:0] syn_now;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] syn_q, syn_d;
  logic             valid_q, valid_d;
  logic             fatal_q, fatal_d;

  assign syn_now = a_i ^ b_i;
  assign mism    = chk_en_i && (a_i != b_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      syn_q   <= '0;
      valid_q <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      syn_q   <= syn_d;
      valid_q <= valid_d;
      fatal_q <= fatal_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    syn_d   = syn_q;
    valid_d = valid_q;
    fatal_d = fatal_q;
    // Clear first, then record a coincident event on top of the cleared state.
    if (clr_i) begin
      cnt_d   = '0;
      syn_d   = '0;
      valid_d = 1'b0;
      fatal_d = 1'b0;
    end
    if (mism) begin
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
      if (!valid_d) begin
        syn_d   = syn_now;
        valid_d = 1'b1;
      end
    end
    if (cnt_d >= THRESH) fatal_d = 1'b1;
  end

  alert_sender u_alert_sender (
    .clk     (clk),
    .rst_n   (rst_n),
    .event_i (mism),
    .ack_i   (alert_ack_i),
    .req_o   (alert_o)
  );

  assign err_cnt_o   = cnt_q;
  assign err_syn_o   = syn_q;
  assign err_valid_o = valid_q;
  assign fatal_o     = fatal_q;

endmodule

// File: tb/tb_dup_reg_checker.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_dup_reg_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic       chk_en_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       alert_ack_i = 1'b0;
  logic       alert_o;
  logic [3:0] err_cnt_o;
  logic [7:0] err_syn_o;
  logic       err_valid_o;
  logic       fatal_o;

  typedef struct {
    logic       alert;
    logic [3:0] cnt;
    logic [7:0] syn;
    logic       valid;
    logic       fatal;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  dup_reg_checker #(.WIDTH(8), .CNT_W(4), .FATAL_THRESH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a_i),
    .b_i         (b_i),
    .chk_en_i    (chk_en_i),
    .clr_i       (clr_i),
    .alert_ack_i (alert_ack_i),
    .alert_o     (alert_o),
    .err_cnt_o   (err_cnt_o),
    .err_syn_o   (err_syn_o),
    .err_valid_o (err_valid_o),
    .fatal_o     (fatal_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are registered and always present; one entry per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        cmp("alert_o",     {31'b0, alert_o},     {31'b0, e.alert});
        cmp("err_cnt_o",   {28'b0, err_cnt_o},   {28'b0, e.cnt});
        cmp("err_syn_o",   {24'b0, err_syn_o},   {24'b0, e.syn});
        cmp("err_valid_o", {31'b0, err_valid_o}, {31'b0, e.valid});
        cmp("fatal_o",     {31'b0, fatal_o},     {31'b0, e.fatal});
      end
    end
  end

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic en,
                      input logic clr, input logic ack,
                      input logic ea, input logic [3:0] ec, input logic [7:0] es,
                      input logic ev, input logic ef);
    exp_t e;
    a_i = a; b_i = b; chk_en_i = en; clr_i = clr; alert_ack_i = ack;
    @(posedge clk);
    #1;
    e.alert = ea; e.cnt = ec; e.syn = es; e.valid = ev; e.fatal = ef;
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_alert"}, {31'b0, alert_o},     32'd0);
    cmp({tag, "_cnt"},   {28'b0, err_cnt_o},   32'd0);
    cmp({tag, "_syn"},   {24'b0, err_syn_o},   32'd0);
    cmp({tag, "_valid"}, {31'b0, err_valid_o}, 32'd0);
    cmp({tag, "_fatal"}, {31'b0, fatal_o},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Matching copies: nothing happens.
    for (int i = 0; i < 10; i++) step(8'hA5, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    // Ack in IDLE ignored.
    step(8'hA5, 8'hA5, 1, 0, 1, 0, 0, 8'h00, 0, 0);

    // Single mismatch and full handshake.
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 1, 8'h01, 1, 0);
    step(8'hA5, 8'hA5, 1, 0, 1, 0, 1, 8'h01, 1, 0);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 1, 8'h01, 1, 0);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 1, 8'h01, 1, 0);

    // Three consecutive mismatches; pending produces exactly one extra pulse.
    step(8'hA5, 8'hA5, 1, 1, 0, 0, 0, 8'h00, 0, 0);
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 1, 8'h01, 1, 0);
    step(8'hA5, 8'h25, 1, 0, 0, 1, 2, 8'h01, 1, 0);
    step(8'hA5, 8'h5A, 1, 0, 0, 1, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 1, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 1, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 1, 0, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 1, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 1, 0, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 3, 8'h01, 1, 1);
    for (int i = 0; i < 3; i++) step(8'hA5, 8'hA5, 1, 0, 0, 0, 3, 8'h01, 1, 1);

    // Saturation after 20 mismatches, then disabled mismatch ignored.
    step(8'hA5, 8'hA5, 1, 1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 20; i++)
      step(8'hA5, 8'hA4, 1, 0, 0, 1, (i >= 14) ? 4'd15 : 4'(i + 1), 8'h01, 1, (i >= 2));
    step(8'h00, 8'hFF, 0, 0, 0, 1, 15, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 1, 0, 15, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 15, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 1, 15, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 1, 0, 15, 8'h01, 1, 1);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 15, 8'h01, 1, 1);

    // Build count 5 with fatal, then clear with coincident mismatch.
    step(8'hA5, 8'hA5, 1, 1, 0, 0, 0, 8'h00, 0, 0);
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 1, 8'h01, 1, 0);
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 2, 8'h01, 1, 0);
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 3, 8'h01, 1, 1);
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 4, 8'h01, 1, 1);
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 5, 8'h01, 1, 1);
    step(8'hA5, 8'hB5, 1, 1, 0, 1, 1, 8'h10, 1, 0);

    // Reset mid-handshake: outputs drop asynchronously, pending is lost.
    @(negedge clk);
    #1;
    cmp("pre_reset_alert", {31'b0, alert_o}, 32'd1);
    a_i = 8'hA5; b_i = 8'hA5; clr_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(8'hA5, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    step(8'hA5, 8'hA4, 1, 0, 0, 1, 1, 8'h01, 1, 0);
    step(8'hA5, 8'hA5, 1, 0, 1, 0, 1, 8'h01, 1, 0);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 1, 8'h01, 1, 0);
    step(8'hA5, 8'hA5, 1, 0, 0, 0, 1, 8'h01, 1, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dup_reg_checker.md
Name: dup_reg_checker

Overview:
- Consumer side of duplicated flip-flop storage: reads the two redundant copies of a WIDTH-bit register and compares them every enabled cycle.
- Captures the first-error syndrome, keeps a saturating mismatch counter, and raises a fatal flag at a threshold.
- Signals each mismatch event to the alert handler over a 4-phase req/ack handshake.
- Sits next to any duplicated register bank; it is the detection end that fault-injection campaigns on redundant flops are scored against.

Parameters:
- WIDTH, 8, width of each redundant copy.
- CNT_W, 4, width of the mismatch counter.
- FATAL_THRESH, 3, counter value at or above which fatal_o asserts (1 ≤ FATAL_THRESH ≤ 2^CNT_W-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a_i  in  WIDTH  primary copy.
- b_i  in  WIDTH  shadow copy.
- chk_en_i  in  1  compare enable; when low, copies are ignored.
- clr_i  in  1  synchronous clear of counter, syndrome, fatal.
- alert_ack_i  in  1  alert handler acknowledge.
- alert_o  out  1  alert request (4-phase).
- err_cnt_o  out  CNT_W  saturating mismatch-cycle count.
- err_syn_o  out  WIDTH  a_i^b_i of first mismatch since reset/clear.
- err_valid_o  out  1  err_syn_o holds a captured syndrome.
- fatal_o  out  1  sticky, err_cnt_o ≥ FATAL_THRESH.

Behaviour:
- Reset (async, rst_n=0): alert_o=0, err_cnt_o=0, err_syn_o=0, err_valid_o=0, fatal_o=0, FSM=IDLE, pending=0.
- All outputs are registered.
- mism = chk_en_i & (a_i != b_i), combinational.
- Every state update happens on the same edge that samples mism, so latency is 1 cycle.
- Counter:
  - On a mism cycle, err_cnt increments, saturating at 2^CNT_W-1. It never wraps.
- Syndrome:
  - On a mism cycle with err_valid=0, err_syn←a_i^b_i and err_valid←1.
  - Later mismatches do not overwrite it.
- fatal_o:
  - Set on the edge where the next err_cnt ≥ FATAL_THRESH.
  - Cleared only by clr_i or reset.
- clr_i:
  - Zeroes err_cnt, err_syn, err_valid, fatal.
  - If mism is in the same cycle, the clear applies first and the new event is then recorded: err_cnt=1, err_syn=new syndrome, err_valid=1, fatal per threshold.
  - clr_i does not touch the alert FSM or pending.
- Alert FSM states: IDLE, REQ, WAIT_LOW.
  - IDLE: if mism or pending, go to REQ with alert_o=1 on the next cycle, and clear pending.
  - REQ: alert_o=1; when alert_ack_i=1, go to WAIT_LOW with alert_o=0.
  - WAIT_LOW: alert_o=0; when alert_ack_i=0, go to IDLE.
  - A mism in REQ or WAIT_LOW sets pending (single bit; multiple events collapse into one).
  - pending re-triggers REQ once from IDLE. The IDLE→REQ transition consumes pending, even with a simultaneous mism.
  - alert_ack_i high while in IDLE is ignored.
- chk_en_i=0: no mism and no state change, apart from an in-flight handshake continuing.
- Reset mid-handshake: alert_o drops asynchronously; the FSM goes to IDLE and pending is lost.
- X-free: unknown chk_en_i is not tolerated. The bench drives known values.

Decomposition:
- Package fifoss_chk_pkg holds:
  - typedef enum logic [1:0] {ALERT_IDLE, ALERT_REQ, ALERT_WAIT_LOW} alert_state_e;
  - localparam default threshold.
- One sub-module, alert_sender: the req/ack FSM plus the pending bit.
  - Inputs: clk, rst_n, event_i, ack_i.
  - Output: req_o.
  - Reusable by other checkers.
- The counter, syndrome and fatal logic stay in dup_reg_checker.

Test Plan:
- Reset, then a_i=b_i=8'hA5, chk_en_i=1 for 10 cycles → alert_o=0, err_cnt_o=0, err_valid_o=0, fatal_o=0 throughout.
- One cycle a_i=8'hA5, b_i=8'hA4 → next cycle err_cnt_o=1, err_syn_o=8'h01, err_valid_o=1, alert_o=1. Ack high → alert_o=0 next cycle. Ack low → FSM IDLE.
- 3 consecutive mismatch cycles (syndromes 8'h01, 8'h80, 8'hFF) with ack held low → err_cnt_o=3, err_syn_o=8'h01, fatal_o=1, alert_o held 1. After the ack cycle completes, a second alert pulse from pending appears, and only one.
- 20 mismatch cycles with CNT_W=4 → err_cnt_o saturates at 15. Mismatch with chk_en_i=0 → no change.
- clr_i with a simultaneous mismatch (syndrome 8'h10) after err_cnt_o=5, fatal_o=1 → err_cnt_o=1, err_syn_o=8'h10, fatal_o=0.
- rst_n pulsed low while alert_o=1 → all outputs 0 immediately. The FSM restarts in IDLE with no stale pending alert.
